// File: rtl/fixed_mult_pkg.sv
// Shared constants and FSM encoding for the fixed-point multiplier arbiter.
// Q16.16 format parameters plus the width of the overflow event counter.
package fixed_mult_pkg;

    localparam int WIDTH     = 32;
    localparam int FRAC_BITS = 16;
    localparam int OVF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_t;

endpackage

// File: rtl/fixed_point_mult_arbiter_mult.sv
// Combinational signed fixed-point multiplier: truncating (floor) shift of the
// full-width product, wrapping result, flag when the result is not representable.
module FixedPointMultiplier #(
    parameter int WIDTH     = fixed_mult_pkg::WIDTH,
    parameter int FRAC_BITS = fixed_mult_pkg::FRAC_BITS
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] p_out,
    output logic             overflow
);
    import fixed_mult_pkg::*;

    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;
    logic        [WIDTH:0] hi;

    assign prod    = PW'($signed(a_in)) * PW'($signed(b_in));
    assign prod_sh = prod >>> FRAC_BITS;
    assign p_out   = prod_sh[WIDTH-1:0];

    // Bits above the result (plus its sign bit) must all be copies of the sign.
    assign hi       = prod_sh[PW-1:WIDTH-1];
    assign overflow = ~((&hi) | ~(|hi));

endmodule

// File: rtl/fixed_point_mult_arbiter.sv
// Round-robin arbiter that time-shares one Q16.16 multiplier among N_REQ
// requesters and returns each product on a single backpressured channel.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting; grants first valid requester at/after rr_ptr
//   COMPUTE | operands latched; product and flag registered this cycle
//   RESP    | resp_valid high, result held until resp_ready
module fixed_point_mult_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = fixed_mult_pkg::WIDTH,
    parameter int FRAC_BITS = fixed_mult_pkg::FRAC_BITS,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     req_valid,
    output logic [N_REQ-1:0]                     req_ready,
    input  logic [N_REQ*WIDTH-1:0]               req_a,
    input  logic [N_REQ*WIDTH-1:0]               req_b,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic [WIDTH-1:0]                     resp_p,
    output logic                                 resp_overflow,
    output logic [ID_W-1:0]                      resp_id,
    output logic                                 busy,
    output logic [fixed_mult_pkg::OVF_CNT_W-1:0] ovf_count
);
    import fixed_mult_pkg::*;

    localparam int CW = ID_W + 1;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [ID_W-1:0]   op_id;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [CW-1:0]     pos;
    logic              accept;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic [WIDTH-1:0]  mult_p;
    logic              mult_ovf;

    // Walk downward in offset so the smallest offset from rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        pos         = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + CW'(k);
            if (pos >= CW'(N_REQ)) begin
                pos = pos - CW'(N_REQ);
            end
            if (req_valid[pos[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = pos[ID_W-1:0];
            end
        end
    end

    assign a_sel = req_a[int'(grant_idx) * WIDTH +: WIDTH];
    assign b_sel = req_b[int'(grant_idx) * WIDTH +: WIDTH];

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Reset wins over a same-cycle request: nothing is accepted.
                if (!rst && grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_d              = COMPUTE;
                end
            end
            COMPUTE: state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);

    FixedPointMultiplier #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_mult (
        .a_in     (op_a),
        .b_in     (op_b),
        .p_out    (mult_p),
        .overflow (mult_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr        <= '0;
            op_a          <= '0;
            op_b          <= '0;
            op_id         <= '0;
            resp_p        <= '0;
            resp_overflow <= 1'b0;
            resp_id       <= '0;
            ovf_count     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a   <= a_sel;
                op_b   <= b_sel;
                op_id  <= grant_idx;
                rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_q == COMPUTE) begin
                resp_p        <= mult_p;
                resp_overflow <= mult_ovf;
                resp_id       <= op_id;
            end
            if (state_q == RESP && resp_ready && resp_overflow && ovf_count != '1) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_mult_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// directed literal cases, then randomized traffic with backpressure and resets.
module tb_fixed_point_mult_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_p;
    logic           resp_overflow;
    logic [1:0]     resp_id;
    logic           busy;
    logic [15:0]    ovf_count;

    fixed_point_mult_arbiter #(.N_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_p        (resp_p),
        .resp_overflow (resp_overflow),
        .resp_id       (resp_id),
        .busy          (busy),
        .ovf_count     (ovf_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // requester-side pending operands
    logic        pend_v [N];
    logic [31:0] pend_a [N];
    logic [31:0] pend_b [N];

    // reference model state
    int          m_ptr;
    bit          m_inflight;
    int          m_age;
    logic [31:0] m_p;
    bit          m_ovf;
    int          m_id;
    int          m_ovf_cnt;
    bit          m_resp_zero;
    int          accepted;

    // observations of delivered results
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_lat = -1;
    bit          prev_rv = 1'b0;
    int          n_deliv = 0;
    logic [31:0] last_p;
    bit          last_ovf;
    int          last_id;
    int          ids[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] p, output bit ovf);
        longint pr;
        longint sh;
        longint hi;
        pr  = longint'($signed(a)) * longint'($signed(b));
        sh  = pr >>> 16;
        p   = sh[31:0];
        hi  = pr >>> 47;
        ovf = !(hi == 0 || hi == -1);
    endfunction

    function automatic int rr_pick(input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (pend_v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: rand_op = v;
            1: rand_op = {{12{v[19]}}, v[19:0]};
            2: rand_op = (v[0]) ? 32'h0001_0000 : ((v[1]) ? 32'hFFFF_FFFF : 32'h0);
            default: rand_op = {16'h7FFF ^ {15'd0, v[16]}, v[15:0]};
        endcase
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend_v[i];
            req_a[i*W +: W]    = pend_a[i];
            req_b[i*W +: W]    = pend_b[i];
        end
    endtask

    task automatic step();
        int         g;
        logic [N-1:0] er;
        bit         ev;
        @(negedge clk);
        g  = (!rst && !m_inflight) ? rr_pick(m_ptr) : -1;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ev = m_inflight && (m_age >= 1);
        check("req_ready", req_ready, er);
        check("resp_valid", resp_valid, ev);
        check("busy", busy, m_inflight);
        check("ovf_count", ovf_count, m_ovf_cnt);
        if (ev) begin
            check("resp_p", resp_p, m_p);
            check("resp_overflow", resp_overflow, m_ovf);
            check("resp_id", resp_id, m_id);
        end
        if (m_resp_zero) begin
            check("rst_resp_p", resp_p, 0);
            check("rst_resp_overflow", resp_overflow, 0);
            check("rst_resp_id", resp_id, 0);
        end
        if (req_ready != '0) acc_cyc = cyc;
        if (resp_valid && !prev_rv) last_lat = cyc - acc_cyc;
        prev_rv = resp_valid;
        if (resp_valid && resp_ready) begin
            last_p   = resp_p;
            last_ovf = resp_overflow;
            last_id  = int'(resp_id);
            n_deliv++;
            ids.push_back(int'(resp_id));
        end
        accepted = -1;
        if (rst) begin
            m_inflight  = 1'b0;
            m_ptr       = 0;
            m_ovf_cnt   = 0;
            m_resp_zero = 1'b1;
        end else if (!m_inflight) begin
            if (g >= 0) begin
                m_inflight = 1'b1;
                m_age      = 0;
                ref_mul(pend_a[g], pend_b[g], m_p, m_ovf);
                m_id       = g;
                m_ptr      = (g + 1) % N;
                accepted   = g;
            end
        end else if (m_age == 0) begin
            m_age       = 1;
            m_resp_zero = 1'b0;
        end else if (resp_ready) begin
            m_inflight = 1'b0;
            if (m_ovf && m_ovf_cnt < 65535) m_ovf_cnt++;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (accepted >= 0) pend_v[accepted] = 1'b0;
        drive();
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (pend_v[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string nm);
        for (int t = 0; t < 300 && (any_pending() || m_inflight); t++) step();
        check({nm, "_drained"}, any_pending() || m_inflight, 0);
    endtask

    task automatic run_one(input string nm, input int idx, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_p, input bit exp_ovf);
        int n0;
        n0 = n_deliv;
        pend_v[idx] = 1'b1;
        pend_a[idx] = a;
        pend_b[idx] = b;
        drive();
        for (int t = 0; t < 40 && n_deliv == n0; t++) step();
        check({nm, "_delivered"}, n_deliv - n0, 1);
        check({nm, "_p"}, last_p, exp_p);
        check({nm, "_ovf"}, last_ovf, exp_ovf);
        check({nm, "_id"}, last_id, idx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n0;
        int nacc;
        bit got;

        rst        = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_a[i] = '0;
            pend_b[i] = '0;
        end
        drive();
        m_ptr = 0; m_inflight = 0; m_age = 0; m_p = '0; m_ovf = 0; m_id = 0;
        m_ovf_cnt = 0; m_resp_zero = 1'b1; accepted = -1;

        step();
        step();
        rst = 1'b0;

        run_one("single", 0, 32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 1'b0);
        check("single_latency", last_lat, 2);
        run_one("signed", 2, 32'hFFFE_0000, 32'h0003_0000, 32'hFFFA_0000, 1'b0);
        run_one("zero", 2, 32'h0000_0000, 32'h0003_0000, 32'h0000_0000, 1'b0);
        run_one("wrap", 0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);

        // rr_ptr must now point at 1: with 0 and 1 both valid, 1 goes first.
        base = ids.size();
        pend_v[0] = 1'b1; pend_a[0] = 32'h0000_8000; pend_b[0] = 32'h0004_0000;
        pend_v[1] = 1'b1; pend_a[1] = 32'h0003_0000; pend_b[1] = 32'hFFFF_0000;
        drive();
        drain("ptr");
        check("ptr_first_id", ids.size() > base ? ids[base] : -1, 1);
        check("ptr_second_id", ids.size() > base + 1 ? ids[base+1] : -1, 0);
        check("ptr_first_p", last_p, 32'h0002_0000);

        run_one("ovf", 3, 32'h7FFF_0000, 32'h0002_0000, 32'hFFFE_0000, 1'b1);
        check("ovf_count_lit", ovf_count, 1);

        // fairness: all four continuously valid
        base = ids.size();
        nacc = 0;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b1; pend_a[i] = rand_op(); pend_b[i] = rand_op();
        end
        drive();
        for (int t = 0; t < 80 && ids.size() < base + 5; t++) begin
            step();
            if (accepted >= 0) begin
                nacc++;
                if (nacc <= 4) begin
                    pend_v[accepted] = 1'b1;
                    pend_a[accepted] = rand_op();
                    pend_b[accepted] = rand_op();
                    drive();
                end
            end
        end
        for (int k = 0; k < 5; k++)
            check($sformatf("fair_id%0d", k), ids.size() > base + k ? ids[base+k] : -1, k % N);
        drain("fair");

        // backpressure
        resp_ready = 1'b0;
        pend_v[1] = 1'b1; pend_a[1] = 32'h0001_8000; pend_b[1] = 32'h0002_0000;
        drive();
        for (int t = 0; t < 10 && !(m_inflight && m_age == 1); t++) step();
        pend_v[2] = 1'b1; pend_a[2] = 32'hFFFF_8000; pend_b[2] = 32'hFFFF_8000;
        drive();
        n0 = n_deliv;
        for (int t = 0; t < 10; t++) step();
        check("bp_no_transfer", n_deliv - n0, 0);
        check("bp_held_p", resp_p, 32'h0003_0000);
        resp_ready = 1'b1;
        step();
        check("bp_one_transfer", n_deliv - n0, 1);
        check("bp_id", last_id, 1);
        drain("bp");
        check("bp_pending_served", last_id, 2);
        check("bp_pending_p", last_p, 32'h0000_4000);

        // reset while COMPUTE
        pend_v[0] = 1'b1; pend_a[0] = 32'h0005_0000; pend_b[0] = 32'h0002_0000;
        drive();
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            step();
            got = (accepted == 0);
        end
        check("rst_accepted0", got, 1);
        rst = 1'b1;
        pend_v[1] = 1'b1; pend_a[1] = 32'h0004_0000; pend_b[1] = 32'hFFFF_8000;
        drive();
        step();
        rst = 1'b0;
        check("rst_lit_valid", resp_valid, 0);
        check("rst_lit_busy", busy, 0);
        check("rst_lit_p", resp_p, 0);
        check("rst_lit_ovf_count", ovf_count, 0);
        n0 = n_deliv;
        drain("rst");
        check("rst_after_count", n_deliv - n0, 1);
        check("rst_after_id", last_id, 1);
        check("rst_after_p", last_p, 32'hFFFE_0000);

        // randomized traffic
        for (int t = 0; t < 800; t++) begin
            resp_ready = ($urandom_range(0, 9) < 7);
            rst        = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 3) == 0) begin
                    pend_v[i] = 1'b1;
                    pend_a[i] = rand_op();
                    pend_b[i] = rand_op();
                end
            end
            drive();
            step();
        end
        rst = 1'b0;
        resp_ready = 1'b1;
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixed_point_mult_arbiter.md
# fixed_point_mult_arbiter

Round-robin arbiter and sequencer that shares one combinational Q16.16 fixed-point multiplier among N_REQ requesters. Each requester presents an operand pair over a valid/ready handshake. The block grants one requester at a time, registers the operands and then the product, and returns result, overflow flag and requester ID on a single backpressured response channel. It sits between the datapath clients (filters, accumulators) and the shared multiplier.

## Interface
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 32, operand/result width, Q16.16 two's complement
- FRAC_BITS, 16, fractional bits
- ID_W, $clog2(N_REQ), requester ID width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_p  out  WIDTH  Q16.16 product
- resp_overflow  out  1  product not representable in Q16.16
- resp_id  out  ID_W  index of requester that owns this result
- busy  out  1  high in any state other than IDLE
- ovf_count  out  16  saturating count of overflowed results delivered

## Operation
- FSM states: IDLE, COMPUTE, RESP.
- IDLE: if any req_valid is high, grant the first valid index at or after rr_ptr, searching upward with wrap. Assert req_ready[grant] combinationally in the same cycle. On that edge, latch req_a/req_b of the grant and the grant index into op_a/op_b/op_id, set rr_ptr = (grant+1) mod N_REQ, and go to COMPUTE. With no valid, stay in IDLE and hold rr_ptr.
- COMPUTE: drive op_a/op_b into the multiplier and register p_out, overflow and op_id into the resp_* registers. Go to RESP.
- RESP: resp_valid=1. resp_p, resp_overflow and resp_id stay stable until resp_valid && resp_ready. On that transfer, go to IDLE and increment ovf_count if resp_overflow (stop at 0xFFFF).
- req_ready is zero in COMPUTE and RESP. Only one requester is ever in flight.
- Arithmetic, in the multiplier: full signed 64-bit product of the two operands. The result is product[47:16], a truncating arithmetic shift right by FRAC_BITS that rounds toward −inf. overflow=1 when product[63:47] is not all-equal. The result wraps and is never saturated.
- req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready. Once asserted, req_valid and operands are held until accepted.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_p=0, resp_overflow=0, resp_id=0, busy=0, ovf_count=0. Also state=IDLE and rr_ptr=0.
- Latency: accept at edge N, then resp_valid high from edge N+2.
- Peak throughput is one result per 3 cycles, with resp_ready held high.
- Backpressure: with resp_ready low, the block holds RESP indefinitely. New requests are not accepted and their req_valid stays pending.
- Fairness: with all N_REQ requesters continuously valid, grants rotate 0,1,…,N_REQ−1,0. Each requester waits at most N_REQ−1 other transactions.
- rst during COMPUTE or RESP aborts the transaction. The result is discarded and never presented. Outputs return to reset values on the next edge.
- rst and req_valid in the same cycle: reset wins, req_ready=0 and nothing is accepted.
- Wrap: rr_ptr=N_REQ−1 with only requester 0 valid grants 0 and sets rr_ptr=1.

## Structure
- Package fixed_mult_pkg holds:
  - WIDTH=32 and FRAC_BITS=16
  - the state enum {IDLE, COMPUTE, RESP}
  - OVF_CNT_W=16
- One sub-module, FixedPointMultiplier, is the existing combinational Q16.16 multiplier with ports a_in, b_in, p_out, overflow. It is instantiated once and fed from op_a/op_b.
- Round-robin grant is a function or a generate loop inside the arbiter. It is not a separate module.

## Test plan
- Single request: requester 0 sends a=0x00020000, b=0x00030000 → resp_p=0x00060000, overflow=0, id=0, resp_valid two cycles after accept.
- Signed and zero operands: requester 2 sends a=0xFFFE0000, b=0x00030000 → resp_p=0xFFFA0000, id=2. Then a=0, b=0x00030000 → resp_p=0.
- Overflow: a=0x7FFF0000, b=0x00020000 → overflow=1, resp_p=0xFFFE0000 (wrapped), ovf_count=1 after transfer.
- Fairness: all 4 requesters hold valid with distinct operands → resp_id sequence 0,1,2,3,0, each result matching its operands.
- Backpressure: hold resp_ready=0 for 10 cycles in RESP → resp_* stable and req_ready=0 throughout. Releasing completes exactly one transfer.
- Reset mid-op: assert rst in COMPUTE → resp_valid never rises for that op. All outputs are 0 and rr_ptr=0 next cycle. The next request from requester 1 completes normally.
